// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle of the dual-clock FIFO: write request, synchronized read
// pointer in, and the RAM address / Gray pointer / status flags out.
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  winc;
  logic                  ovf_clr;
  logic [ADDR_WIDTH:0]   wq2_rptr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  wen;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  woverflow;

  modport master (
    output winc, ovf_clr, wq2_rptr,
    input  waddr, wptr, wen, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, ovf_clr, wq2_rptr,
    output waddr, wptr, wen, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and status generator for the dual-clock FIFO: binary and
// Gray write pointers, full / almost-full / fill level, sticky overflow.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_MARGIN  = 1
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wptr_full_if.slave  bus
);
  localparam int AW    = ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wptr_q;
  logic          wfull_q;
  logic          walmost_full_q;
  logic [PW-1:0] wlevel_q;
  logic          woverflow_q;

  logic          wen_int;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_match;
  logic          wfull_next;
  logic          walmost_full_next;
  logic          woverflow_next;

  // A write attempted while full is dropped here, so the pointer never moves.
  assign wen_int    = bus.winc & ~wfull_q;
  assign wbin_next  = wbin + {{AW{1'b0}}, wen_int};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  always_comb begin
    rbin_s = '0;
    rbin_s[PW-1] = bus.wq2_rptr[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ bus.wq2_rptr[i];
    end
  end

  // Full when the next write pointer equals the read pointer with its two
  // MSBs inverted (Gray form of "one lap ahead").
  assign full_match        = {~bus.wq2_rptr[AW:AW-1], bus.wq2_rptr[AW-2:0]};
  assign wfull_next        = (wgray_next == full_match);
  assign level_next        = wbin_next - rbin_s;
  assign walmost_full_next = (level_next >= AF_THRESH);

  always_comb begin
    woverflow_next = woverflow_q;
    if (bus.winc && wfull_q) begin
      woverflow_next = 1'b1;
    end else if (bus.ovf_clr) begin
      woverflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin           <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin           <= wbin_next;
      wptr_q         <= wgray_next;
      wfull_q        <= wfull_next;
      walmost_full_q <= walmost_full_next;
      wlevel_q       <= level_next;
      woverflow_q    <= woverflow_next;
    end
  end

  // wptr is driven straight from its flop; the read-domain synchronizer
  // depends on it changing at most one bit per cycle.
  assign bus.waddr        = wbin[AW-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wen          = wen_int;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = woverflow_q;
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side pointer and status generator for the dual-clock FIFO; lives entirely in the write clock domain.
- Produces the write address for the RAM and the Gray-coded write pointer that the read domain captures through its two-flop synchronizer.
- Computes full, almost-full, fill level and a sticky overflow flag, using the read pointer synchronized into this domain (Gray, ADDR_WIDTH+1 bits).

Parameters:
- ADDR_WIDTH, 3, RAM address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range >= 2.
- AF_MARGIN, 1, almost_full asserts when fill level >= DEPTH - AF_MARGIN; legal range 0..DEPTH-1.

Ports:
- clk  in  1  write-domain clock
- rst_n  in  1  asynchronous active-low reset
- winc  in  1  write request for this cycle
- ovf_clr  in  1  clears the sticky overflow flag
- wq2_rptr  in  ADDR_WIDTH+1  read pointer (Gray), already synchronized into clk
- waddr  out  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0]
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer
- wen  out  1  RAM write enable = winc & ~wfull (combinational)
- wfull  out  1  registered full flag
- walmost_full  out  1  registered almost-full flag
- wlevel  out  ADDR_WIDTH+1  registered fill level, 0..DEPTH
- woverflow  out  1  sticky flag: a write was attempted while full

Behaviour:
- Reset (async assert, sync deassert handled upstream): wbin, wptr, wfull, walmost_full, wlevel and woverflow all clear to 0, so waddr=0.
- Reset mid-operation: all state clears immediately; no partial pointer update is retained.

Pointer update:
- Internal registers: wbin (binary) and wptr (Gray).
- wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1).
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- Both pointers register on posedge clk.
- wptr changes by at most one bit per cycle; this is mandatory for CDC safety.
- wptr must come straight from a flop, with no combinational logic on the output.

Full:
- wfull <= (wgray_next == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]}), where AW = ADDR_WIDTH.
- Latency: the write that fills the FIFO asserts wfull on the next edge.
- wfull deasserts on the edge after wq2_rptr advances.
- wfull is pessimistic by the synchronizer delay. It must never report not-full while DEPTH entries are held.

Level and almost-full:
- rbin_s = Gray-to-binary of wq2_rptr (XOR prefix from the MSB).
- wlevel <= wbin_next - rbin_s, computed at ADDR_WIDTH+1 bits with modulo wrap. The wrap gives the correct result across pointer wrap-around.
- walmost_full <= (wbin_next - rbin_s) >= DEPTH - AF_MARGIN.
- With AF_MARGIN=0, walmost_full equals wfull.

Overflow:
- woverflow <= 1 when winc & wfull.
- Otherwise it clears when ovf_clr is high. If winc & wfull and ovf_clr occur in the same cycle, set wins.
- A write while full is dropped: wen=0 and no pointer change.

Other rules:
- Simultaneous write and read-pointer advance: both are folded into the same next-state computation. Level is unchanged if exactly one write occurs and rptr advances by one.
- No state machine beyond the pointer counters; no X may propagate from wq2_rptr while rst_n is low.

Test Plan (ADDR_WIDTH=3, AF_MARGIN=1, wq2_rptr held at 0 unless stated):
- Reset: pulse rst_n low asynchronously mid-cycle -> all outputs 0 immediately; waddr=0, wptr=4'b0000.
- Fill: 8 consecutive winc -> wptr sequence 0001,0011,0010,0110,0111,0101,0100,1100. Also:
  - walmost_full=1 after the 7th write.
  - wfull=1 and wlevel=8 after the 8th write.
  - wen=0 on a 9th winc.
- Overflow: with wfull=1, assert winc for 1 cycle -> woverflow=1 and wptr unchanged at 1100. Then:
  - ovf_clr=1 -> woverflow=0 next edge.
  - ovf_clr together with winc while full -> woverflow stays 1.
- Drain: from full, set wq2_rptr=4'b0001 -> next edge wfull=0, wlevel=7, walmost_full=1. Then wq2_rptr=4'b0011 -> wlevel=6, walmost_full=0.
- Wrap-around: write 8, read-sync to 1100, write 8 more (wq2_rptr=1100) -> wptr returns to 0000, wfull=1 with wlevel=8.
- Simultaneous: at wlevel=4, winc=1 while wq2_rptr advances one step in the same cycle -> wlevel stays 4. Check Gray single-bit change on wptr every cycle via assertion.
